// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA digit display controller.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONV    = 2'd1,
        ST_WAIT_VS = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    localparam int CTRL_DEC  = 0;
    localparam int CTRL_SYNC = 1;

    localparam logic [31:0] OVF_LIMIT = 32'd99_999_999;
    localparam int          BCD_W     = 40;

    // Double-dabble correction: digits of 5 or more get +3 before the shift.
    function automatic logic [3:0] add3(input logic [3:0] digit);
        if (digit >= 4'd5) begin
            return digit + 4'd3;
        end else begin
            return digit;
        end
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit double-dabble converter, one bit per cycle, MSB first.
module bin2bcd_seq
    import vga_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      din,
    output logic             done,
    output logic [BCD_W-1:0] bcd,
    output logic             ovf
);

    logic [31:0]      bin_r;
    logic [BCD_W-1:0] bcd_r;
    logic [BCD_W-1:0] bcd_adj_s;
    logic [4:0]       cnt_r;
    logic             active_r;
    logic             done_r;
    logic             ovf_r;

    // Add-3 correction applied to every digit ahead of the shift.
    always_comb begin
        bcd_adj_s = '0;
        for (int i = 0; i < BCD_W / 4; i++) begin
            bcd_adj_s[i*4 +: 4] = add3(bcd_r[i*4 +: 4]);
        end
    end

    // done is raised one cycle early so the caller leaves on the final shift edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r    <= 32'd0;
            bcd_r    <= '0;
            cnt_r    <= 5'd0;
            active_r <= 1'b0;
            done_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (start) begin
            bin_r    <= din;
            bcd_r    <= '0;
            cnt_r    <= 5'd0;
            active_r <= 1'b1;
            done_r   <= 1'b0;
            ovf_r    <= (din > OVF_LIMIT);
        end else if (active_r) begin
            bcd_r    <= {bcd_adj_s[BCD_W-2:0], bin_r[31]};
            bin_r    <= {bin_r[30:0], 1'b0};
            cnt_r    <= cnt_r + 5'd1;
            done_r   <= (cnt_r == 5'd30);
            active_r <= (cnt_r != 5'd31);
        end else begin
            done_r   <= 1'b0;
        end
    end

    assign done = done_r;
    assign bcd  = bcd_r;
    assign ovf  = ovf_r;

endmodule

// File: rtl/vga_disp_ctrl.sv
// MMIO-driven eight-digit display controller with hex/decimal modes and
// optional commit on the falling edge of vertical sync.
module vga_disp_ctrl
    import vga_pkg::*;
#(
    parameter logic SYNC_DEFAULT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        wr_sel,
    input  logic [31:0] wr_data,
    input  logic        vs,
    output logic [3:0]  s1,
    output logic [3:0]  s2,
    output logic [3:0]  s3,
    output logic [3:0]  s4,
    output logic [3:0]  s5,
    output logic [3:0]  s6,
    output logic [3:0]  s7,
    output logic [3:0]  s8,
    output logic        busy,
    output logic        ovf
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             pending_r;
    logic             pending_nxt_s;
    logic [31:0]      data_r;
    logic             dec_r;
    logic             sync_en_r;
    logic             vs_d_r;
    logic [31:0]      snap_r;
    logic             snap_dec_r;
    logic [31:0]      disp_r;
    logic             ovf_r;
    logic             busy_r;
    logic             conv_start_s;
    logic             conv_done_s;
    logic [BCD_W-1:0] conv_bcd_s;
    logic             conv_ovf_s;
    logic             dec_ovf_s;

    assign conv_start_s = (state_r == ST_IDLE) && pending_r && dec_r;
    assign dec_ovf_s    = conv_ovf_s || (|conv_bcd_s[BCD_W-1:32]);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start_s),
        .din   (data_r),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s),
        .ovf   (conv_ovf_s)
    );

    // Next state; sync_en is read live so clearing it releases a pending vs wait.
    always_comb begin
        state_nxt_s   = state_r;
        pending_nxt_s = pending_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r) begin
                    pending_nxt_s = 1'b0;
                    if (dec_r) begin
                        state_nxt_s = ST_CONV;
                    end else if (sync_en_r) begin
                        state_nxt_s = ST_WAIT_VS;
                    end else begin
                        state_nxt_s = ST_COMMIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (conv_done_s) begin
                    state_nxt_s = sync_en_r ? ST_WAIT_VS : ST_COMMIT;
                end else begin
                    state_nxt_s = ST_CONV;
                end
            end
            ST_WAIT_VS: begin
                if (!sync_en_r || (vs_d_r && !vs)) begin
                    state_nxt_s = ST_COMMIT;
                end else begin
                    state_nxt_s = ST_WAIT_VS;
                end
            end
            ST_COMMIT: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
        if (wr_en) begin
            pending_nxt_s = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // Register file, snapshot, FSM state and the atomically committed outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pending_r  <= 1'b0;
            data_r     <= 32'd0;
            dec_r      <= 1'b0;
            sync_en_r  <= SYNC_DEFAULT;
            vs_d_r     <= 1'b1;
            snap_r     <= 32'd0;
            snap_dec_r <= 1'b0;
            disp_r     <= 32'd0;
            ovf_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            pending_r <= pending_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE) || pending_nxt_s;
            vs_d_r    <= vs;
            if (wr_en && !wr_sel) begin
                data_r <= wr_data;
            end
            if (wr_en && wr_sel) begin
                dec_r     <= wr_data[CTRL_DEC];
                sync_en_r <= wr_data[CTRL_SYNC];
            end
            if ((state_r == ST_IDLE) && pending_r) begin
                snap_r     <= data_r;
                snap_dec_r <= dec_r;
            end
            if (state_r == ST_COMMIT) begin
                if (snap_dec_r) begin
                    disp_r <= dec_ovf_s ? 32'h9999_9999 : conv_bcd_s[31:0];
                    ovf_r  <= dec_ovf_s;
                end else begin
                    disp_r <= snap_r;
                    ovf_r  <= 1'b0;
                end
            end
        end
    end

    assign s1   = disp_r[31:28];
    assign s2   = disp_r[27:24];
    assign s3   = disp_r[23:20];
    assign s4   = disp_r[19:16];
    assign s5   = disp_r[15:12];
    assign s6   = disp_r[11:8];
    assign s7   = disp_r[7:4];
    assign s8   = disp_r[3:0];
    assign busy = busy_r;
    assign ovf  = ovf_r;

endmodule

// File: doc/vga_disp_ctrl.md
VGA_DISP_CTRL -- requirements
Module: vga_disp_ctrl

Interface
REQ-001 SHALL have parameter SYNC_DEFAULT, default 1, reset value of the frame-sync enable bit.
REQ-002 SHALL have port clk  input  1  system clock, the same clock that drives the VGA character renderer.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port wr_en  input  1  CPU MMIO write strobe, one cycle per write.
REQ-005 SHALL have port wr_sel  input  1  write target: 0 = data register, 1 = control register.
REQ-006 SHALL have port wr_data  input  32  write data.
REQ-007 SHALL have port vs  input  1  vertical sync from the VGA timing block, active low.
REQ-008 SHALL have ports s1..s8  output  4 each  digit codes to the renderer; s1 is the leftmost and most significant digit.
REQ-009 SHALL have port busy  output  1  high while a conversion or commit is outstanding.
REQ-010 SHALL have port ovf  output  1  decimal overflow flag for the currently displayed value.

Function
REQ-011 SHALL implement the control register as bit0 = dec (0 hex, 1 decimal) and bit1 = sync_en; other bits are ignored.
REQ-012 SHALL, on wr_en with wr_sel=0, capture wr_data into data_reg and set pending.
REQ-013 SHALL, on wr_en with wr_sel=1, update the control register and set pending so the display re-renders in the new mode.
REQ-014 SHALL implement FSM states IDLE, CONV, WAIT_VS and COMMIT.
REQ-015 SHALL, in IDLE with pending set:
- snapshot data_reg and dec;
- clear pending;
- go to CONV if dec=1, otherwise go to WAIT_VS if sync_en=1, otherwise go to COMMIT.
REQ-016 SHALL, in CONV, perform a sequential double-dabble conversion:
- exactly 32 cycles, one bit per cycle, MSB first;
- add-3 correction on each BCD digit >=5 before the shift;
- 40-bit BCD accumulator;
- then go to WAIT_VS if sync_en=1, otherwise go to COMMIT.
REQ-017 SHALL, in decimal mode with snapshot > 99_999_999, produce digits 9,9,9,9,9,9,9,9 and ovf=1 at commit; otherwise ovf=0 at commit. Hex mode always gives ovf=0.
REQ-018 SHALL, in hex mode, map snapshot[31:28] to s1 through snapshot[3:0] to s8.
REQ-019 SHALL, in WAIT_VS:
- register vs once per cycle into vs_d;
- leave to COMMIT on the falling edge (vs_d=1 and vs=0).
REQ-020 SHALL, in COMMIT, load all eight s outputs and ovf together in one edge, then return to IDLE; outputs SHALL never show a partial update.
REQ-021 SHALL drive busy=1 in every state other than IDLE, and also in IDLE while pending=1.
REQ-022 SHALL, on writes during CONV, WAIT_VS or COMMIT:
- update data_reg/control and set pending;
- not disturb the in-flight snapshot;
- start the new value from IDLE after COMMIT (last write wins).
REQ-023 SHALL, for a write accepted in IDLE at cycle N with sync_en=0, make the new outputs visible from cycle N+2 in hex mode and from cycle N+34 in decimal mode.
REQ-024 SHALL apply a control write that clears sync_en while in WAIT_VS on the next cycle, going to COMMIT without waiting for vs.

Reset
REQ-025 SHALL, on rst high, asynchronously set:
- s1..s8 = 0, ovf = 0, busy = 0;
- data_reg = 0, pending = 0, dec = 0;
- sync_en = SYNC_DEFAULT, vs_d = 1;
- FSM = IDLE.
REQ-026 SHALL abandon any conversion or wait on reset mid-operation; no commit occurs after rst deasserts until a new write.

Structure
REQ-027 SHALL place the FSM state encoding, the control bit indices and the overflow limit 99_999_999 in shared package vga_pkg.
REQ-028 SHALL contain one sub-module, bin2bcd_seq: a sequential 32-bit double-dabble converter with start/done handshake, 40-bit BCD output and overflow output.

Verification
REQ-029 SHALL cover hex mode, sync_en=0: write 0x12AB_CDEF at cycle N -> s1..s8 = 1,2,A,B,C,D,E,F from N+2; ovf=0.
REQ-030 SHALL cover decimal mode, sync_en=0: write 12345678 -> s1..s8 = 1..8 from N+34; busy high from N to N+33.
REQ-031 SHALL cover decimal overflow: write 0xFFFF_FFFF -> s1..s8 all 9 and ovf=1.
REQ-032 SHALL cover sync_en=1: write 0x0000_0001, then hold vs high 100 cycles -> outputs unchanged; drive vs low -> s8=1 on the following edge and busy falls.
REQ-033 SHALL cover back-to-back writes during CONV: write 5, then write 7 at N+10 -> 5 is displayed, then 7; final s8=7 and busy=0.
REQ-034 SHALL cover reset mid-CONV: pulse rst at N+15 -> all outputs 0, busy 0, no later commit.
